// File: rtl/tfd_meter.sv
// Measures period (rise to rise) and high time of sig in clk cycles; results lag sig by SYNC+1 cycles.
// No backpressure: vld is a fire-and-forget strobe; a missing input is flagged through ovf/ovf_flag.
module tfd_meter #(
  parameter int WIDTH = 32,
  parameter int SYNC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st,
  input  logic             sig,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high,
  output logic             vld,
  output logic             busy,
  output logic             ovf,
  output logic             ovf_flag
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] MEAS = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hcnt;
  logic             sig_s;
  logic             sig_d;
  logic             rise;

  generate
    if (SYNC == 0) begin : g_nosync
      assign sig_s = sig;
    end else begin : g_sync
      logic [SYNC-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= sig;
          for (int i = 1; i < SYNC; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign sig_s = sync_q[SYNC-1];
    end
  endgenerate

  assign rise = sig_s & ~sig_d;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hcnt     <= '0;
      period   <= '0;
      high     <= '0;
      vld      <= 1'b0;
      ovf      <= 1'b0;
      ovf_flag <= 1'b0;
      sig_d    <= 1'b0;
    end else begin
      sig_d <= sig_s;
      vld   <= 1'b0;
      ovf   <= 1'b0;
      case (state)
        IDLE: begin
          if (st) begin
            state    <= ARM;
            ovf_flag <= 1'b0;
          end
        end
        ARM: begin
          if (!st) begin
            state <= IDLE;
          end else if (rise) begin
            cnt   <= WIDTH'(1);
            hcnt  <= WIDTH'(1);
            state <= MEAS;
          end
        end
        MEAS: begin
          // st low wins over a coincident rise; a rise wins over saturation
          if (!st) begin
            state <= IDLE;
          end else if (rise) begin
            period <= cnt;
            high   <= hcnt;
            vld    <= 1'b1;
            cnt    <= WIDTH'(1);
            hcnt   <= WIDTH'(1);
          end else if (cnt == {WIDTH{1'b1}}) begin
            ovf      <= 1'b1;
            ovf_flag <= 1'b1;
            state    <= ARM;
          end else begin
            cnt  <= cnt + WIDTH'(1);
            hcnt <= hcnt + WIDTH'(sig_s);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
